// File: rtl/fd_multiciclo.sv
// fd_multiciclo: multi-cycle datapath executing ADD/SUB/ADDI/SUBI/LD/SD per start request
// Register bank and data memory are cleared by reset; R0 is never written.
module fd_multiciclo #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int MEM_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [REG_ADDR_W-1:0] ra,
    input  logic [REG_ADDR_W-1:0] rb,
    input  logic [REG_ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0]     offset,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_W-1:0]     dout_a,
    output logic [DATA_W-1:0]     dout_b,
    output logic [DATA_W-1:0]     result,
    output logic [DATA_W-1:0]     dout_mem
);
    typedef enum logic [2:0] {IDLE, RD, EX, MEM, WB, FIN} state_t;
    state_t state, next;
    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] ra_q, rb_q, rw_q;
    logic [DATA_W-1:0]     off_q;
    logic [DATA_W-1:0]     bank [2**REG_ADDR_W];
    logic [DATA_W-1:0]     mem  [2**MEM_ADDR_W];
    logic [DATA_W-1:0]     alu;
    logic                  illegal, is_mem, is_ld, fault, abort;

    always_comb begin
        alu = '0;
        case (op_q)
            3'd0: alu = dout_a + dout_b;
            3'd1: alu = dout_a - dout_b;
            3'd2: alu = dout_a + off_q;
            3'd3: alu = dout_a - off_q;
            3'd4, 3'd5: alu = dout_b + off_q;
            default: alu = '0;
        endcase
    end

    assign illegal = op_q > 3'd5;
    assign is_ld   = op_q == 3'd4;
    assign is_mem  = is_ld || op_q == 3'd5;
    // Any address bit beyond the memory index range is a fault
    assign fault   = |alu[DATA_W-1:MEM_ADDR_W];
    assign abort   = illegal || (is_mem && fault);

    always_comb begin
        next = IDLE;
        case (state)
            IDLE:    next = start ? RD : IDLE;
            RD:      next = EX;
            EX:      next = abort ? FIN : is_mem ? MEM : WB;
            MEM:     next = is_ld ? WB : FIN;
            WB:      next = FIN;
            FIN:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            dout_a   <= '0;
            dout_b   <= '0;
            result   <= '0;
            dout_mem <= '0;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rw_q     <= '0;
            off_q    <= '0;
            for (int i = 0; i < 2**REG_ADDR_W; i++) bank[i] <= '0;
            for (int i = 0; i < 2**MEM_ADDR_W; i++) mem[i] <= '0;
        end else begin
            state <= next;
            busy  <= next != IDLE;
            // done lands in the IDLE cycle following FIN
            done  <= state == FIN;
            case (state)
                IDLE: if (start) begin
                    op_q  <= op;
                    ra_q  <= ra;
                    rb_q  <= rb;
                    rw_q  <= rw;
                    off_q <= offset;
                    err   <= 1'b0;
                end
                RD: begin
                    dout_a <= bank[ra_q];
                    dout_b <= bank[rb_q];
                end
                EX: begin
                    result <= alu;
                    err    <= abort;
                end
                MEM: if (is_ld) dout_mem <= mem[result[MEM_ADDR_W-1:0]];
                     else mem[result[MEM_ADDR_W-1:0]] <= dout_a;
                WB: if (rw_q != '0) bank[rw_q] <= is_ld ? dout_mem : result;
                default: ;
            endcase
        end
    end
endmodule
